// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: stalls on load-use and busy-MDU hazards, flushes on
// taken branches, and keeps a saturating count of stall cycles.
module hazard_detection_unit #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IF_ID_RegisterRs,
    input  logic [4:0]           IF_ID_RegisterRt,
    input  logic                 IF_ID_UsesRs,
    input  logic                 IF_ID_UsesRt,
    input  logic                 IF_ID_ReadsHiLo,
    input  logic                 IF_ID_StartsMdu,
    input  logic                 ID_EX_MemRead,
    input  logic [4:0]           ID_EX_RegisterRt,
    input  logic                 Branch_Taken,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 MduBusy,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int MduCntWidth = $clog2(MDU_LATENCY + 1);

    logic [MduCntWidth-1:0] mduCnt;
    logic                   loadUse;
    logic                   mduHaz;
    logic                   stall;
    logic                   issue;

    // A load into $zero never produces a usable value, so it never forces a stall.
    always_comb begin
        loadUse = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                  ((IF_ID_UsesRs && (IF_ID_RegisterRs == ID_EX_RegisterRt)) ||
                   (IF_ID_UsesRt && (IF_ID_RegisterRt == ID_EX_RegisterRt)));
        MduBusy     = (mduCnt != '0);
        mduHaz      = MduBusy && (IF_ID_ReadsHiLo || IF_ID_StartsMdu);
        stall       = !reset && !Branch_Taken && (loadUse || mduHaz);
        issue       = IF_ID_StartsMdu && !stall && !Branch_Taken && !reset;
        PCWrite     = !stall;
        IF_ID_Write = !stall;
        ID_EX_Flush = stall || Branch_Taken || reset;
        IF_ID_Flush = Branch_Taken || reset;
    end

    // A second MDU op is held by mduHaz while busy, so a reload never lands mid-count.
    always_ff @(posedge clk) begin
        if (reset) begin
            mduCnt     <= '0;
            StallCount <= '0;
        end else begin
            if (issue) begin
                mduCnt <= MduCntWidth'(MDU_LATENCY);
            end else if (mduCnt != '0) begin
                mduCnt <= mduCnt - MduCntWidth'(1);
            end
            if (stall && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit with a 4-cycle MDU and a 4-bit stall counter.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_RegisterRt;
    logic       IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_ReadsHiLo, IF_ID_StartsMdu;
    logic       ID_EX_MemRead, Branch_Taken;
    logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduBusy;
    logic [3:0] StallCount;
    logic [4:0] ctrl;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [4:0] CtrlIdle     = 5'b11000;
    localparam logic [4:0] CtrlLuStall  = 5'b00010;
    localparam logic [4:0] CtrlMduStall = 5'b00011;
    localparam logic [4:0] CtrlBusy     = 5'b11001;
    localparam logic [4:0] CtrlFlushAll = 5'b11110;

    hazard_detection_unit #(.MDU_LATENCY(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
        .IF_ID_ReadsHiLo(IF_ID_ReadsHiLo), .IF_ID_StartsMdu(IF_ID_StartsMdu),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRt(ID_EX_RegisterRt),
        .Branch_Taken(Branch_Taken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MduBusy(MduBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    assign ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduBusy};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0; ID_EX_RegisterRt = 5'd0;
        IF_ID_UsesRs = 1'b0; IF_ID_UsesRt = 1'b0; IF_ID_ReadsHiLo = 1'b0;
        IF_ID_StartsMdu = 1'b0; ID_EX_MemRead = 1'b0; Branch_Taken = 1'b0;
    endtask

    task automatic loadUsePattern;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5;
        IF_ID_RegisterRs = 5'd5; IF_ID_UsesRs = 1'b1;
    endtask

    task automatic pulseReset;
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clearInputs();
        loadUsePattern();
        reset = 1'b1;
        #1;
        assertCount++;
        if (ctrl !== CtrlFlushAll) begin
            failCount++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, CtrlFlushAll);
        end
        tick();
        assertCount++;
        if (StallCount !== 4'd0 || MduBusy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_state: got cnt=%0d busy=%b expected cnt=0 busy=0", StallCount, MduBusy);
        end
        reset = 1'b0;
        clearInputs();
        #1;
        assertCount++;
        if (ctrl !== CtrlIdle) begin
            failCount++;
            $display("[TB] FAIL idle_ctrl: got %b expected %b", ctrl, CtrlIdle);
        end
    endtask

    task automatic test_load_use;
        pulseReset();
        loadUsePattern();
        #1;
        assertCount++;
        if (ctrl !== CtrlLuStall) begin
            failCount++;
            $display("[TB] FAIL loaduse_rs_ctrl: got %b expected %b", ctrl, CtrlLuStall);
        end
        tick();
        assertCount++;
        if (StallCount !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL loaduse_count: got %0d expected 1", StallCount);
        end
        // Load into $zero with a matching source: no stall.
        ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0;
        #1;
        assertCount++;
        if (ctrl !== CtrlIdle) begin
            failCount++;
            $display("[TB] FAIL loaduse_zero: got %b expected %b", ctrl, CtrlIdle);
        end
        tick();
        ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3;
        IF_ID_RegisterRt = 5'd5; IF_ID_UsesRt = 1'b0;
        #1;
        assertCount++;
        if (ctrl !== CtrlIdle) begin
            failCount++;
            $display("[TB] FAIL loaduse_rt_unused: got %b expected %b", ctrl, CtrlIdle);
        end
        tick();
        IF_ID_UsesRt = 1'b1;
        #1;
        assertCount++;
        if (ctrl !== CtrlLuStall) begin
            failCount++;
            $display("[TB] FAIL loaduse_rt_ctrl: got %b expected %b", ctrl, CtrlLuStall);
        end
        tick();
        ID_EX_MemRead = 1'b0;
        #1;
        assertCount++;
        if (ctrl !== CtrlIdle || StallCount !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL loaduse_bubble: got ctrl=%b cnt=%0d expected ctrl=%b cnt=2", ctrl, StallCount, CtrlIdle);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_mdu;
        pulseReset();
        IF_ID_StartsMdu = 1'b1;
        #1;
        assertCount++;
        if (ctrl !== CtrlIdle) begin
            failCount++;
            $display("[TB] FAIL mdu_issue_ctrl: got %b expected %b", ctrl, CtrlIdle);
        end
        tick();
        IF_ID_StartsMdu = 1'b0; IF_ID_ReadsHiLo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            assertCount++;
            if (ctrl !== CtrlMduStall) begin
                failCount++;
                $display("[TB] FAIL mdu_hilo_stall[%0d]: got %b expected %b", i, ctrl, CtrlMduStall);
            end
            tick();
        end
        assertCount++;
        if (ctrl !== CtrlIdle || StallCount !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL mdu_hilo_release: got ctrl=%b cnt=%0d expected ctrl=%b cnt=4", ctrl, StallCount, CtrlIdle);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_back_to_back;
        pulseReset();
        IF_ID_StartsMdu = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            assertCount++;
            if (ctrl !== CtrlMduStall) begin
                failCount++;
                $display("[TB] FAIL b2b_stall[%0d]: got %b expected %b", i, ctrl, CtrlMduStall);
            end
            tick();
        end
        assertCount++;
        if (ctrl !== CtrlIdle) begin
            failCount++;
            $display("[TB] FAIL b2b_second_issue: got %b expected %b", ctrl, CtrlIdle);
        end
        tick();
        IF_ID_StartsMdu = 1'b0;
        // Reloaded counter: busy for four more cycles without stalling anything.
        for (int i = 0; i < 4; i++) begin
            #1;
            assertCount++;
            if (ctrl !== CtrlBusy) begin
                failCount++;
                $display("[TB] FAIL b2b_reload[%0d]: got %b expected %b", i, ctrl, CtrlBusy);
            end
            tick();
        end
        assertCount++;
        if (ctrl !== CtrlIdle || StallCount !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL b2b_done: got ctrl=%b cnt=%0d expected ctrl=%b cnt=4", ctrl, StallCount, CtrlIdle);
        end
    endtask

    task automatic test_branch_priority;
        pulseReset();
        loadUsePattern();
        IF_ID_StartsMdu = 1'b1; Branch_Taken = 1'b1;
        #1;
        assertCount++;
        if (ctrl !== CtrlFlushAll) begin
            failCount++;
            $display("[TB] FAIL branch_ctrl: got %b expected %b", ctrl, CtrlFlushAll);
        end
        tick();
        Branch_Taken = 1'b0; IF_ID_StartsMdu = 1'b0; ID_EX_MemRead = 1'b0;
        #1;
        assertCount++;
        if (StallCount !== 4'd0 || MduBusy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL branch_state: got cnt=%0d busy=%b expected cnt=0 busy=0", StallCount, MduBusy);
        end
        clearInputs();
    endtask

    task automatic test_reset_mid;
        pulseReset();
        loadUsePattern();
        repeat (7) tick();
        clearInputs();
        IF_ID_StartsMdu = 1'b1;
        tick();
        IF_ID_StartsMdu = 1'b0;
        tick();
        tick();
        assertCount++;
        if (StallCount !== 4'd7 || ctrl !== CtrlBusy) begin
            failCount++;
            $display("[TB] FAIL midop_setup: got cnt=%0d ctrl=%b expected cnt=7 ctrl=%b", StallCount, ctrl, CtrlBusy);
        end
        loadUsePattern();
        reset = 1'b1;
        #1;
        assertCount++;
        if (ctrl !== 5'b11111) begin
            failCount++;
            $display("[TB] FAIL midop_reset_ctrl: got %b expected 11111", ctrl);
        end
        tick();
        assertCount++;
        if (StallCount !== 4'd0 || MduBusy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midop_after: got cnt=%0d busy=%b expected cnt=0 busy=0", StallCount, MduBusy);
        end
        reset = 1'b0;
        clearInputs();
    endtask

    task automatic test_saturation;
        logic [3:0] expCount;
        pulseReset();
        loadUsePattern();
        for (int i = 1; i <= 20; i++) begin
            tick();
            expCount = (i > 15) ? 4'd15 : 4'(i);
            assertCount++;
            if (StallCount !== expCount) begin
                failCount++;
                $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", i, StallCount, expCount);
            end
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_mdu();
        test_back_to_back();
        test_branch_priority();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall/flush controller for the five-stage MIPS pipeline. It sits on the ID stage, upstream of the EX-stage operand forwarding logic. It holds instructions in ID when forwarding cannot supply an operand in time: load-use hazards and HI/LO reads or new MDU ops while the multi-cycle multiply/divide unit is busy. It also flushes wrong-path instructions on a taken branch and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MDU_LATENCY, 32, cycles the MDU stays busy after a mult/div enters EX; must be ≥1
- CNT_WIDTH, 32, width of StallCount

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- IF_ID_RegisterRs  in  5  rs of the instruction in ID
- IF_ID_RegisterRt  in  5  rt of the instruction in ID
- IF_ID_UsesRs  in  1  instruction in ID reads rs
- IF_ID_UsesRt  in  1  instruction in ID reads rt
- IF_ID_ReadsHiLo  in  1  instruction in ID is mfhi/mflo
- IF_ID_StartsMdu  in  1  instruction in ID is mult/multu/div/divu
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRt  in  5  load destination register in EX
- Branch_Taken  in  1  branch/jump resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero the IF/ID register at the next edge
- ID_EX_Flush  out  1  insert a bubble (control zeros) into ID/EX at the next edge
- MduBusy  out  1  MDU result not yet available
- StallCount  out  CNT_WIDTH  saturating count of stall cycles

## Operation
- State: mdu_cnt, width $clog2(MDU_LATENCY+1), unsigned; StallCount.
- LoadUse = ID_EX_MemRead && ID_EX_RegisterRt≠0 && ((IF_ID_UsesRs && IF_ID_RegisterRs==ID_EX_RegisterRt) || (IF_ID_UsesRt && IF_ID_RegisterRt==ID_EX_RegisterRt)).
- MduBusy = (mdu_cnt≠0).
- MduHaz = MduBusy && (IF_ID_ReadsHiLo || IF_ID_StartsMdu).
- Stall = !reset && !Branch_Taken && (LoadUse || MduHaz).
- Outputs:
  - PCWrite = !Stall
  - IF_ID_Write = !Stall
  - ID_EX_Flush = Stall || Branch_Taken || reset
  - IF_ID_Flush = Branch_Taken || reset
- Branch priority: Branch_Taken overrides every stall. Instructions in IF and ID are wrong-path. PC loads the target. No stall is counted.
- MDU issue: Issue = IF_ID_StartsMdu && !Stall && !Branch_Taken && !reset.
  - On Issue, mdu_cnt ← MDU_LATENCY.
  - Otherwise, if mdu_cnt≠0, mdu_cnt ← mdu_cnt−1.
  - Issue while busy cannot occur because MduHaz stalls it, so the counter never reloads mid-count.
- StallCount: increments by 1 on every edge where Stall=1. Holds at all-ones (no wrap).
- Reset (synchronous): mdu_cnt←0 and StallCount←0 at the edge, including mid-MDU-operation. While reset is high, Stall=0, PCWrite=1, IF_ID_Write=1, and both flushes are 1.
- $zero: a load to register 0 never causes a stall.

## Timing
- Stall, PCWrite, IF_ID_Write, both flushes and MduBusy are combinational from the current inputs and state. No added latency; they are valid in the same cycle as the hazard.
- Load-use: exactly one stall cycle. The bubble clears ID_EX_MemRead on the next cycle.
- MDU: Issue at edge E. MduBusy=1 for exactly MDU_LATENCY cycles after E (mdu_cnt = L, L−1, …, 1). A dependent mfhi/mflo is held in ID for those cycles and advances on the first cycle with mdu_cnt=0.
- StallCount and mdu_cnt update only on rising clk edges. After reset, the first valid value is 0.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5, IF_ID_UsesRs=1 → PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, StallCount 0→1. Repeat with ID_EX_RegisterRt=0, or with the Rt match but IF_ID_UsesRt=0 → no stall.
- MDU: MDU_LATENCY=4, IF_ID_StartsMdu=1 for one cycle, then IF_ID_ReadsHiLo=1 held → MduBusy=1 and Stall=1 for exactly 4 cycles, then PCWrite=1. StallCount=4.
- Back-to-back MDU: second mult in ID while busy → stalls until mdu_cnt=0. Then Issue reloads mdu_cnt to 4.
- Branch priority: Branch_Taken=1 together with a load-use match and IF_ID_StartsMdu=1 → PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1. StallCount unchanged and mdu_cnt not loaded.
- Reset mid-operation: assert reset when mdu_cnt=2 and StallCount=7 → after the edge, MduBusy=0 and StallCount=0. During reset, both flushes are 1 and PCWrite=1.
- Saturation: CNT_WIDTH=4, hold a load-use hazard pattern for 20 stall cycles → StallCount=15 and stays at 15.
